// File: rtl/multi_byte_add_seq.sv
// Byte-serial NBYTES-wide add/subtract sequencer built around one shared
// 8-bit ripple-carry adder; start/busy/done handshake, LSB byte first.

module ripple_carry_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cy_in,
   output logic [7:0] sum,
   output logic       cy_out
);

   always_comb begin
      logic [8:0] c;
      c      = '0;
      sum    = '0;
      c[0]   = cy_in;
      for (int unsigned i = 0; i < 8; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cy_out = c[8];
   end

endmodule

module multi_byte_add_seq #(
   parameter int unsigned NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  sub,
   input  logic                  cin,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  cout,
   output logic                  overflow
);

   localparam int unsigned W  = 8 * NBYTES;
   localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   logic [1:0]    state;
   logic [W-1:0]  a_reg;
   logic [W-1:0]  b_reg;
   logic [IW-1:0] idx;
   logic          carry;

   logic [7:0]    a_byte;
   logic [7:0]    b_byte;
   logic [7:0]    sum_byte;
   logic          cy_out;

   // {idx, 3'b000} is the bit offset of the active byte slice
   assign a_byte = a_reg[{idx, 3'b000} +: 8];
   assign b_byte = b_reg[{idx, 3'b000} +: 8];

   ripple_carry_adder u_rca (
      .a      (a_byte),
      .b      (b_byte),
      .cy_in  (carry),
      .sum    (sum_byte),
      .cy_out (cy_out)
   );

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_reg    <= '0;
         b_reg    <= '0;
         idx      <= '0;
         carry    <= 1'b0;
         result   <= '0;
         cout     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= op_a;
                  // subtraction is A + ~B + 1
                  b_reg <= sub ? ~op_b : op_b;
                  carry <= sub ? 1'b1 : cin;
                  idx   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               result[{idx, 3'b000} +: 8] <= sum_byte;
               carry <= cy_out;
               idx   <= idx + IW'(1);
               if (idx == LAST_IDX) begin
                  cout     <= cy_out;
                  overflow <= (a_reg[W-1] == b_reg[W-1]) && (sum_byte[7] != a_reg[W-1]);
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Self-checking bench for multi_byte_add_seq at NBYTES=4 and NBYTES=2 against
// an arithmetic reference model.

module tb_multi_byte_add_seq;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        start4, sub4, cin4;
   logic [31:0] a4, b4;
   logic        busy4, done4, cout4, ov4;
   logic [31:0] res4;

   logic        start2, sub2, cin2;
   logic [15:0] a2, b2;
   logic        busy2, done2, cout2, ov2;
   logic [15:0] res2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   multi_byte_add_seq #(.NBYTES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .sub(sub4), .cin(cin4),
      .op_a(a4), .op_b(b4), .busy(busy4), .done(done4), .result(res4),
      .cout(cout4), .overflow(ov4)
   );

   multi_byte_add_seq #(.NBYTES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .cin(cin2),
      .op_a(a2), .op_b(b2), .busy(busy2), .done(done2), .result(res2),
      .cout(cout2), .overflow(ov2)
   );

   // Reference: {cout,result} = A + B_eff + cin_eff modulo 2^(8*nb); returns {ov, cout, result}
   function automatic logic [33:0] ref_op(input int nb, input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input logic c);
      logic [63:0] mask, av, beff, tot, res;
      int msb;
      mask = (64'd1 << (8 * nb)) - 64'd1;
      av   = {32'b0, a} & mask;
      beff = (s ? ~{32'b0, b} : {32'b0, b}) & mask;
      tot  = av + beff + (s ? 64'd1 : {63'b0, c});
      res  = tot & mask;
      msb  = 8 * nb - 1;
      return {(av[msb] == beff[msb]) && (res[msb] != av[msb]), tot[8 * nb], res[31:0]};
   endfunction

   // Runs one operation; k counts samples taken 1 time unit after each edge, k=1 after the start edge.
   task automatic do_op(input bit use2, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic c,
                        output logic [31:0] r, output logic co, output logic ov,
                        output int busy_n, output int done_at, output int done_n, output bit timeout);
      logic bsy, dn;
      @(negedge clk);
      if (use2) begin start2 = 1'b1; a2 = a[15:0]; b2 = b[15:0]; sub2 = s; cin2 = c; end
      else      begin start4 = 1'b1; a4 = a;       b4 = b;       sub4 = s; cin4 = c; end
      @(posedge clk); #1;
      start2 = 1'b0; start4 = 1'b0;
      a4 = $urandom; b4 = $urandom; sub4 = 1'($urandom); cin4 = 1'($urandom);
      a2 = 16'($urandom); b2 = 16'($urandom); sub2 = 1'($urandom); cin2 = 1'($urandom);
      busy_n = 0; done_at = 0; done_n = 0; timeout = 1'b1;
      r = '0; co = 1'b0; ov = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         bsy = use2 ? busy2 : busy4;
         dn  = use2 ? done2 : done4;
         if (bsy) busy_n++;
         if (dn) begin
            done_n++;
            if (done_at == 0) done_at = k;
            r  = use2 ? {16'b0, res2} : res4;
            co = use2 ? cout2 : cout4;
            ov = use2 ? ov2 : ov4;
         end
         if (done_at != 0 && !dn) begin
            timeout = 1'b0;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (busy4 !== 1'b0)    begin errors++; $display("FAIL reset_busy got=%b exp=0", busy4); end
      checks++; if (done4 !== 1'b0)    begin errors++; $display("FAIL reset_done got=%b exp=0", done4); end
      checks++; if (res4 !== 32'h0)    begin errors++; $display("FAIL reset_result got=%h exp=0", res4); end
      checks++; if (cout4 !== 1'b0)    begin errors++; $display("FAIL reset_cout got=%b exp=0", cout4); end
      checks++; if (ov4 !== 1'b0)      begin errors++; $display("FAIL reset_ovf got=%b exp=0", ov4); end
      checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || res2 !== 16'h0)
         begin errors++; $display("FAIL reset_dut2 got busy=%b done=%b res=%h exp 0/0/0", busy2, done2, res2); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_add_carry();
      logic [31:0] r; logic co, ov; int bn, da, dn; bit to;
      do_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, co, ov, bn, da, dn, to);
      checks++; if (to !== 1'b0)       begin errors++; $display("FAIL add_carry_timeout got=%b exp=0", to); end
      checks++; if (r !== 32'h0)       begin errors++; $display("FAIL add_carry_result got=%h exp=00000000", r); end
      checks++; if (co !== 1'b1)       begin errors++; $display("FAIL add_carry_cout got=%b exp=1", co); end
      checks++; if (ov !== 1'b0)       begin errors++; $display("FAIL add_carry_ovf got=%b exp=0", ov); end
      checks++; if (bn != 4)           begin errors++; $display("FAIL add_carry_busy_cycles got=%0d exp=4", bn); end
      checks++; if (da != 5)           begin errors++; $display("FAIL add_carry_done_latency got=%0d exp=5", da); end
      checks++; if (dn != 1)           begin errors++; $display("FAIL add_carry_done_width got=%0d exp=1", dn); end
   endtask

   task automatic test_sub();
      logic [31:0] r; logic co, ov; int bn, da, dn; bit to;
      do_op(1'b0, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, r, co, ov, bn, da, dn, to);
      checks++; if (to !== 1'b0 || r !== 32'hFFFF_FFFF)
         begin errors++; $display("FAIL sub_borrow_result got=%h exp=ffffffff timeout=%b", r, to); end
      checks++; if (co !== 1'b0)       begin errors++; $display("FAIL sub_borrow_cout got=%b exp=0", co); end
      checks++; if (ov !== 1'b0)       begin errors++; $display("FAIL sub_borrow_ovf got=%b exp=0", ov); end
      // cin must be ignored in subtract mode
      do_op(1'b0, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, r, co, ov, bn, da, dn, to);
      checks++; if (to !== 1'b0 || r !== 32'h7FFF_FFFF)
         begin errors++; $display("FAIL sub_ovf_result got=%h exp=7fffffff timeout=%b", r, to); end
      checks++; if (co !== 1'b1)       begin errors++; $display("FAIL sub_ovf_cout got=%b exp=1", co); end
      checks++; if (ov !== 1'b1)       begin errors++; $display("FAIL sub_ovf_ovf got=%b exp=1", ov); end
   endtask

   task automatic test_add_overflow();
      logic [31:0] r; logic co, ov; int bn, da, dn; bit to;
      do_op(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, r, co, ov, bn, da, dn, to);
      checks++; if (to !== 1'b0 || r !== 32'h8000_0000)
         begin errors++; $display("FAIL add_ovf_result got=%h exp=80000000 timeout=%b", r, to); end
      checks++; if (co !== 1'b0)       begin errors++; $display("FAIL add_ovf_cout got=%b exp=0", co); end
      checks++; if (ov !== 1'b1)       begin errors++; $display("FAIL add_ovf_ovf got=%b exp=1", ov); end
      do_op(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1, r, co, ov, bn, da, dn, to);
      checks++; if (to !== 1'b0 || r !== 32'h2345_678A)
         begin errors++; $display("FAIL add_cin_result got=%h exp=2345678a timeout=%b", r, to); end
      checks++; if (co !== 1'b0)       begin errors++; $display("FAIL add_cin_cout got=%b exp=0", co); end
      checks++; if (ov !== 1'b0)       begin errors++; $display("FAIL add_cin_ovf got=%b exp=0", ov); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] av [18];
      logic [33:0] exp;
      b4 = 32'h0102_0304; sub4 = 1'b0; cin4 = 1'b0;
      for (int k = 0; k < 18; k++) begin
         @(negedge clk);
         start4 = 1'b1;
         a4 = $urandom;
         av[k] = a4;
         @(posedge clk); #1;
         checks++; if (busy4 !== ((k % 6) < 4))
            begin errors++; $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy4, (k % 6) < 4); end
         checks++; if (done4 !== ((k % 6) == 4))
            begin errors++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done4, (k % 6) == 4); end
         if ((k % 6) == 4) begin
            exp = ref_op(4, av[k - 4], 32'h0102_0304, 1'b0, 1'b0);
            checks++; if ({ov4, cout4, res4} !== exp)
               begin errors++; $display("FAIL b2b_result k=%0d got=%h/%b/%b exp=%h/%b/%b", k, res4, cout4, ov4, exp[31:0], exp[32], exp[33]); end
         end
      end
      @(negedge clk);
      start4 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      logic [31:0] r; logic co, ov; int bn, da, dn, seen; bit to;
      logic [33:0] exp;
      @(negedge clk);
      start4 = 1'b1; a4 = 32'hFFFF_FFFF; b4 = 32'hFFFF_FFFF; sub4 = 1'b0; cin4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk); #1;
      checks++; if (busy4 !== 1'b0 || done4 !== 1'b0)
         begin errors++; $display("FAIL midrst_state got busy=%b done=%b exp 0/0", busy4, done4); end
      checks++; if (res4 !== 32'h0)    begin errors++; $display("FAIL midrst_result got=%h exp=0", res4); end
      checks++; if (cout4 !== 1'b0 || ov4 !== 1'b0)
         begin errors++; $display("FAIL midrst_flags got cout=%b ovf=%b exp 0/0", cout4, ov4); end
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         @(posedge clk); #1;
         if (done4 || busy4) seen++;
      end
      checks++; if (seen != 0)         begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
      do_op(1'b0, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b0, r, co, ov, bn, da, dn, to);
      exp = ref_op(4, 32'hDEAD_BEEF, 32'h1357_9BDF, 1'b1, 1'b0);
      checks++; if (to !== 1'b0 || {ov, co, r} !== exp)
         begin errors++; $display("FAIL midrst_fresh got=%h/%b/%b exp=%h/%b/%b timeout=%b", r, co, ov, exp[31:0], exp[32], exp[33], to); end
   endtask

   task automatic test_random(input bit use2, input int n_ops);
      logic [31:0] r, a, b; logic co, ov, s, c; int bn, da, dn; bit to;
      logic [33:0] exp;
      int nb;
      nb = use2 ? 2 : 4;
      for (int i = 0; i < n_ops; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom); c = 1'($urandom);
         if (use2) begin a[31:16] = '0; b[31:16] = '0; end
         do_op(use2, a, b, s, c, r, co, ov, bn, da, dn, to);
         exp = ref_op(nb, a, b, s, c);
         checks++; if (to !== 1'b0 || da != nb + 1 || dn != 1)
            begin errors++; $display("FAIL rand%0d_timing op=%0d timeout=%b done_at=%0d exp=%0d done_n=%0d", nb, i, to, da, nb + 1, dn); end
         checks++; if (r !== exp[31:0])
            begin errors++; $display("FAIL rand%0d_result op=%0d got=%h exp=%h", nb, i, r, exp[31:0]); end
         checks++; if (co !== exp[32])
            begin errors++; $display("FAIL rand%0d_cout op=%0d got=%b exp=%b", nb, i, co, exp[32]); end
         checks++; if (ov !== exp[33])
            begin errors++; $display("FAIL rand%0d_ovf op=%0d got=%b exp=%b", nb, i, ov, exp[33]); end
      end
   endtask

   initial begin
      start4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; a4 = '0; b4 = '0;
      start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
      test_reset();
      test_add_carry();
      test_sub();
      test_add_overflow();
      test_back_to_back();
      test_reset_mid_run();
      test_random(1'b0, 1000);
      test_random(1'b1, 1000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
